// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame layout and controller state encoding.
// The peripheral register block uses the same field positions.
package spi_pkg;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int BIT_CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/spi_sclk_divider.sv
// Mode-0 sclk generator: CLK_DIV cycles high then CLK_DIV low while enabled,
// starting high on the first enabled cycle. Strobes flag the edge about to happen.
module spi_sclk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);
    localparam int W = $clog2(CLK_DIV + 1);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_sclk;
    logic         r_run;
    logic         w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
            r_run  <= 1'b0;
        end else begin
            r_run <= i_en;
            if (!i_en) begin
                r_cnt  <= '0;
                r_sclk <= 1'b0;
            end else if (!r_run) begin
                // i_en is next-state based, so sclk is already high in the first SHIFT cycle
                r_cnt  <= '0;
                r_sclk <= 1'b1;
            end else if (w_last) begin
                r_cnt  <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_rise = r_run && !r_sclk && w_last;
    assign o_fall = r_run && r_sclk && w_last;
endmodule

// File: rtl/spi_controller.sv
// SPI Mode-0 master: one 16-bit register-write frame per valid/ready request,
// MSB first, with chip-select setup/hold/gap timing. All outputs are registered.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_sclk,
    output logic              o_copi,
    output logic              o_ncs,
    output logic              o_busy,
    output logic              o_done
);
    localparam int PH_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);
    localparam logic [PH_W-1:0]      SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]      HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [PH_W-1:0]      GAP_LAST   = PH_W'(CS_GAP - 1);
    localparam logic [BIT_CNT_W-1:0] BITS_ALL   = BIT_CNT_W'(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] SHIFTS     = BIT_CNT_W'(FRAME_BITS - 1);

    spi_state_e            r_state, w_state_nxt;
    logic [PH_W-1:0]       r_ph;
    logic [BIT_CNT_W-1:0]  r_bits;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  r_ncs, r_busy, r_done, r_ready;
    logic                  w_accept, w_sclk, w_rise, w_fall, w_shift_en;

    assign w_accept = i_req_valid && r_ready;

    always_comb begin
        w_frame                    = '0;
        w_frame[RW_BIT]            = i_req_write;
        w_frame[ADDR_MSB:ADDR_LSB] = i_req_addr;
        w_frame[DATA_W-1:0]        = i_req_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (i_req_valid)                        w_state_nxt = ST_SETUP;
            ST_SETUP: if (r_ph == SETUP_LAST)                 w_state_nxt = ST_SHIFT;
            // leave at the end of the 16th low half-period
            ST_SHIFT: if (w_rise && r_bits == BITS_ALL)       w_state_nxt = ST_HOLD;
            ST_HOLD:  if (r_ph == HOLD_LAST)                  w_state_nxt = ST_GAP;
            ST_GAP:   if (r_ph == GAP_LAST)                   w_state_nxt = ST_IDLE;
            default:                                          w_state_nxt = ST_IDLE;
        endcase
        w_shift_en = (w_state_nxt == ST_SHIFT);
    end

    spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_shift_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ph    <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_ncs   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_ph <= '0;
            else if (r_state inside {ST_SETUP, ST_HOLD, ST_GAP})
                r_ph <= r_ph + 1'b1;

            if (r_state != ST_SHIFT)
                r_bits <= '0;
            else if (w_fall)
                r_bits <= r_bits + 1'b1;

            // copi follows the MSB; the last fall leaves frame[0] in place
            if (w_accept)
                r_shift <= w_frame;
            else if (w_state_nxt == ST_GAP)
                r_shift <= '0;
            else if (w_fall && r_bits < SHIFTS)
                r_shift <= r_shift << 1;

            r_ncs   <= !(w_state_nxt inside {ST_SETUP, ST_SHIFT, ST_HOLD});
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ready <= (w_state_nxt == ST_IDLE);
            r_done  <= (r_state == ST_HOLD) && (w_state_nxt == ST_GAP);
        end
    end

    assign o_sclk      = w_sclk;
    assign o_copi      = r_shift[FRAME_BITS-1];
    assign o_ncs       = r_ncs;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_req_ready = r_ready;
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a default-parameter instance and a fastest-timing instance,
// an arithmetic waveform model checked every cycle, a frame/protocol monitor and directed cases.
module tb_spi_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      valid, write;
    logic [1:0][6:0] addr;
    logic [1:0][7:0] data;
    logic a_sclk, a_copi, a_ncs, a_busy, a_done, a_ready;
    logic b_sclk, b_copi, b_ncs, b_busy, b_done, b_ready;
    logic [1:0] sclk, copi, ncs, busy, done, ready;
    assign sclk  = {b_sclk, a_sclk};
    assign copi  = {b_copi, a_copi};
    assign ncs   = {b_ncs, a_ncs};
    assign busy  = {b_busy, a_busy};
    assign done  = {b_done, a_done};
    assign ready = {b_ready, a_ready};

    spi_controller u_a (
        .clk(clk), .rst_n(rst_n), .i_req_valid(valid[0]), .o_req_ready(a_ready),
        .i_req_write(write[0]), .i_req_addr(addr[0]), .i_req_data(data[0]),
        .o_sclk(a_sclk), .o_copi(a_copi), .o_ncs(a_ncs), .o_busy(a_busy), .o_done(a_done)
    );

    spi_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_b (
        .clk(clk), .rst_n(rst_n), .i_req_valid(valid[1]), .o_req_ready(b_ready),
        .i_req_write(write[1]), .i_req_addr(addr[1]), .i_req_data(data[1]),
        .o_sclk(b_sclk), .o_copi(b_copi), .o_ncs(b_ncs), .o_busy(b_busy), .o_done(b_done)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    function automatic int pS(input int i); return i ? 1 : 2; endfunction
    function automatic int pD(input int i); return i ? 1 : 4; endfunction
    function automatic int pH(input int i); return i ? 1 : 2; endfunction
    function automatic int pG(input int i); return i ? 1 : 4; endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Expected {ncs,sclk,copi,busy,done,ready} k cycles after the first ncs-low cycle.
    function automatic logic [5:0] exp_out(input int k, input logic [15:0] f, input int i, input logic act);
        int S, D, H, G, L, p, b;
        logic [5:0] r;
        S = pS(i); D = pD(i); H = pH(i); G = pG(i);
        L = S + 32 * D + H;
        r = 6'b100001;
        if (act && k >= 0 && k < L + G) begin
            if (k < L) begin
                r = 6'b000100;
                if (k < S) r[3] = f[15];
                else if (k < S + 32 * D) begin
                    p = k - S;
                    r[4] = ((p % (2 * D)) < D);
                    b = (p + D) / (2 * D);
                    if (b > 15) b = 15;
                    r[3] = f[15 - b];
                end else r[3] = f[0];
            end else begin
                r = 6'b100100;
                r[1] = (k == L);
            end
        end
        return r;
    endfunction

    logic        m_act [2];
    int          m_s [2];
    logic [15:0] m_f [2];
    logic [15:0] cap [2];
    int          nrise [2], lowcnt [2], lastlow [2], t_fall [2], t_lastrise [2], t_ncsup [2];
    int          dcnt [2] = '{0, 0};
    logic        p_sclk [2], p_ncs [2], p_copi [2];
    logic [15:0] expq [$];
    int          gapq [$];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic [5:0] act, e;
            act = {ncs[i], sclk[i], copi[i], busy[i], done[i], ready[i]};
            if (!rst_n) begin
                m_act[i] = 1'b0; nrise[i] = 0; lowcnt[i] = 0; cap[i] = '0;
                t_ncsup[i] = -1; t_lastrise[i] = -1; t_fall[i] = -1;
                chk("outputs_in_reset", act, 6'b100001);
            end else begin
                e = exp_out(cyc - m_s[i], m_f[i], i, m_act[i]);
                chk(i ? "b_cycle_outputs" : "a_cycle_outputs", act, e);
                if (p_ncs[i] && ncs[i]) chk("sclk_quiet_while_ncs_high", sclk[i], p_sclk[i]);
                if (p_sclk[i] && sclk[i]) chk("copi_stable_while_sclk_high", copi[i], p_copi[i]);
                if (p_ncs[i] && !ncs[i]) begin
                    t_fall[i] = cyc;
                    if (t_ncsup[i] >= 0) gapq.push_back(cyc - t_ncsup[i]);
                end
                if (!p_sclk[i] && sclk[i]) begin
                    if (nrise[i] == 0) chk("ncs_fall_to_first_rise", cyc - t_fall[i], pS(i));
                    else chk("sclk_period", cyc - t_lastrise[i], 2 * pD(i));
                    t_lastrise[i] = cyc;
                    nrise[i]++;
                    cap[i] = {cap[i][14:0], copi[i]};
                end
                if (!ncs[i]) lowcnt[i]++;
                if (!p_ncs[i] && ncs[i]) begin
                    if (expq.size() > 0) chk("frame_bits", cap[i], expq.pop_front());
                    else chk("unexpected_frame", 1, 0);
                    chk("sclk_rises_per_frame", nrise[i], 16);
                    chk("ncs_low_cycles", lowcnt[i], pS(i) + 32 * pD(i) + pH(i));
                    lastlow[i] = lowcnt[i];
                    t_ncsup[i] = cyc; nrise[i] = 0; lowcnt[i] = 0; cap[i] = '0;
                end
                if (done[i]) dcnt[i]++;
                if (e[0] && valid[i]) begin
                    m_act[i] = 1'b1;
                    m_s[i]   = cyc + 1;
                    m_f[i]   = {write[i], addr[i], data[i]};
                end
            end
            p_sclk[i] = sclk[i]; p_ncs[i] = ncs[i]; p_copi[i] = copi[i];
        end
    end

    task automatic send(input int i, input bit w, input logic [6:0] a, input logic [7:0] d,
                        input logic [15:0] ef, input bit push, input bit hold);
        bit acc;
        acc = 1'b0;
        if (push) expq.push_back(ef);
        write[i] = w; addr[i] = a; data[i] = d; valid[i] = 1'b1;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge clk);
            acc = ready[i];
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        if (!hold) valid[i] = 1'b0;
        write[i] = 1'($urandom); addr[i] = 7'($urandom); data[i] = 8'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy[i] && n < 2000);
        if (busy[i]) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, m, bad;
        valid = '0; write = '0; addr = '0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ncs", ncs, 2'b11);
        chk("reset_sclk", sclk, 2'b00);
        chk("reset_copi", copi, 2'b00);
        chk("reset_busy", busy, 2'b00);
        chk("reset_done", done, 2'b00);
        chk("reset_ready", ready, 2'b11);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single write, default timing
        send(0, 1'b1, 7'h02, 8'hA5, 16'h82A5, 1'b1, 1'b0);
        n = 0;
        while (!ncs[0] && n < 500) begin @(negedge clk); n++; end
        m = 0;
        while (!ready[0] && m < 50) begin @(negedge clk); m++; end
        chk("ready_after_ncs_rise", m, 4);
        wait_idle(0);
        chk("ncs_low_default", lastlow[0], 132);
        chk("done_count_single", dcnt[0], 1);

        // back-to-back with valid held
        gapq.delete();
        send(0, 1'b1, 7'h01, 8'h11, 16'h8111, 1'b1, 1'b1);
        send(0, 1'b1, 7'h03, 8'hFF, 16'h83FF, 1'b1, 1'b1);
        send(0, 1'b1, 7'h00, 8'h00, 16'h8000, 1'b1, 1'b0);
        wait_idle(0);
        chk("b2b_gap_entries", gapq.size(), 3);
        for (int g = 1; g < gapq.size(); g++) chk("b2b_ncs_high_cycles", gapq[g], 5);
        chk("done_count_b2b", dcnt[0], 4);

        // request traffic while busy must be ignored
        send(0, 1'b1, 7'h40, 8'h3C, 16'hC03C, 1'b1, 1'b0);
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            valid[0] = 1'($urandom); write[0] = 1'($urandom);
            addr[0] = 7'($urandom); data[0] = 8'($urandom);
            @(posedge clk);
            #1;
            if (ready[0]) bad++;
        end
        valid[0] = 1'b0;
        chk("ready_low_while_busy", bad, 0);
        wait_idle(0);
        chk("done_count_ignore", dcnt[0], 5);

        // asynchronous reset in the middle of the shift phase
        send(0, 1'b1, 7'h02, 8'h66, 16'h0000, 1'b0, 1'b0);
        n = 0;
        while (nrise[0] < 8 && n < 1000) begin @(posedge clk); #1; n++; end
        chk("reached_bit7", nrise[0], 8);
        @(posedge clk);
        #2;
        chk("pre_abort_ncs_low", ncs[0], 0);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {ncs[0], sclk[0], copi[0], done[0], busy[0]}, 5'b10000);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 1'b1, 7'h05, 8'h3C, 16'h853C, 1'b1, 1'b0);
        wait_idle(0);
        chk("done_count_after_abort", dcnt[0], 6);

        // fastest legal timing, read frame
        send(1, 1'b0, 7'h7F, 8'h5A, 16'h7F5A, 1'b1, 1'b0);
        wait_idle(1);
        chk("ncs_low_fast", lastlow[1], 34);
        chk("done_count_fast", dcnt[1], 1);
        chk("expected_frames_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
